// File: rtl/mem_access_pkg.sv
// Shared definitions for the memory access controller: default widths and
// the controller state encoding. The VERIFY states exist only when
// MEM_ACCESS_CTRL_VERIFY_EN is defined.
package mem_access_pkg;

  localparam int DEF_ADDR_W = 4;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    WRITE        = 3'd1,
    RD_ISSUE     = 3'd2,
    RD_DATA      = 3'd3
`ifdef MEM_ACCESS_CTRL_VERIFY_EN
    ,
    VERIFY_ISSUE = 3'd4,
    VERIFY_CMP   = 3'd5
`endif
  } state_e;

endpackage

// File: rtl/mem_access_ctrl.sv
// Memory access controller: single-beat writes and incrementing burst reads
// against an external synchronous RAM (one-cycle read latency). The RAM sits
// beside this block and is not instantiated here.
// Optional feature macro: MEM_ACCESS_CTRL_VERIFY_EN. When it is defined, every
// write is read back and compared, and a mismatch sets the sticky wr_err flag.
module mem_access_ctrl
  import mem_access_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [ADDR_W-1:0] req_len,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_last,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              wr_err
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [ADDR_W-1:0] beat_q, beat_d;
  logic              mem_en_q, mem_en_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_last_q, rsp_last_d;
  logic              req_ready_q, req_ready_d;
`ifdef MEM_ACCESS_CTRL_VERIFY_EN
  logic              wr_err_q, wr_err_d;
`endif

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_d     = state_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    len_d       = len_q;
    beat_d      = beat_q;
    mem_en_d    = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_last_d  = 1'b0;
    req_ready_d = 1'b0;
`ifdef MEM_ACCESS_CTRL_VERIFY_EN
    wr_err_d    = wr_err_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          mem_addr_d = req_addr;
          if (req_wr) begin
            state_d     = WRITE;
            mem_wdata_d = req_wdata;
            mem_en_d    = 1'b1;
          end else begin
            state_d = RD_ISSUE;
            len_d   = req_len;
            beat_d  = {ADDR_W{1'b0}};
          end
        end else begin
          req_ready_d = 1'b1;
        end
      end
      WRITE: begin
`ifdef MEM_ACCESS_CTRL_VERIFY_EN
        // Read the just-written word back from the same address.
        state_d = VERIFY_ISSUE;
`else
        state_d     = IDLE;
        req_ready_d = 1'b1;
`endif
      end
`ifdef MEM_ACCESS_CTRL_VERIFY_EN
      VERIFY_ISSUE: begin
        state_d = VERIFY_CMP;
      end
      VERIFY_CMP: begin
        if (mem_rdata != mem_wdata_q) begin
          wr_err_d = 1'b1;
        end else begin
          wr_err_d = wr_err_q;
        end
        state_d     = IDLE;
        req_ready_d = 1'b1;
      end
`endif
      RD_ISSUE: begin
        // RAM registers mem_addr at the end of this cycle; data is valid next.
        state_d     = RD_DATA;
        rsp_valid_d = 1'b1;
        rsp_last_d  = (beat_q == len_q);
      end
      RD_DATA: begin
        if (rsp_ready) begin
          if (rsp_last_q) begin
            state_d     = IDLE;
            req_ready_d = 1'b1;
          end else begin
            // Address wraps naturally at 2**ADDR_W.
            state_d    = RD_ISSUE;
            mem_addr_d = mem_addr_q + ADDR_W'(1);
            beat_d     = beat_q + ADDR_W'(1);
          end
        end else begin
          // Hold the beat; mem_addr is unchanged so the RAM keeps returning it.
          rsp_valid_d = 1'b1;
          rsp_last_d  = rsp_last_q;
        end
      end
      default: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
      end
    endcase
  end

  // State and output registers with asynchronous abort on rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      mem_addr_q  <= {ADDR_W{1'b0}};
      mem_wdata_q <= {DATA_W{1'b0}};
      len_q       <= {ADDR_W{1'b0}};
      beat_q      <= {ADDR_W{1'b0}};
      mem_en_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_last_q  <= 1'b0;
      req_ready_q <= 1'b1;
`ifdef MEM_ACCESS_CTRL_VERIFY_EN
      wr_err_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      len_q       <= len_d;
      beat_q      <= beat_d;
      mem_en_q    <= mem_en_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_last_q  <= rsp_last_d;
      req_ready_q <= req_ready_d;
`ifdef MEM_ACCESS_CTRL_VERIFY_EN
      wr_err_q    <= wr_err_d;
`endif
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_last  = rsp_last_q;
  assign mem_en    = mem_en_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  // RAM output is only meaningful while a beat is presented; zero otherwise.
  assign rsp_data  = rsp_valid_q ? mem_rdata : {DATA_W{1'b0}};
`ifdef MEM_ACCESS_CTRL_VERIFY_EN
  assign wr_err    = wr_err_q;
`else
  assign wr_err    = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a behavioural synchronous RAM and a
// shadow copy of its expected contents. Optional macro MEM_ACCESS_CTRL_VERIFY_EN
// enables the write-verify checks.
module tb_mem_access_ctrl;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_wr;
  logic [3:0]  req_addr;
  logic [3:0]  req_len;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_last;
  logic        mem_en;
  logic [3:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        wr_err;

  logic [31:0] ram     [16];
  logic [31:0] exp_mem [16];
  logic        corrupt;

  int n_assert;
  int n_fail;

`ifdef MEM_ACCESS_CTRL_VERIFY_EN
  localparam int WR_LAT = 3;
`else
  localparam int WR_LAT = 1;
`endif

  mem_access_ctrl #(.ADDR_W(4), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_len(req_len), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_last(rsp_last), .mem_en(mem_en), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .wr_err(wr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RAM, one-cycle read latency; corrupt inverts written data.
  always @(posedge clk) begin
    if (mem_en) ram[mem_addr] <= corrupt ? ~mem_wdata : mem_wdata;
    else        mem_rdata     <= ram[mem_addr];
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: observed no finish, required finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input logic [3:0] a, input logic [31:0] d);
    int n;
    req_valid = 1'b1; req_wr = 1'b1; req_addr = a; req_wdata = d;
    check("wr_req_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    req_valid = 1'b0; req_wr = 1'b0;
    check("wr_mem_en", {31'd0, mem_en}, 32'd1);
    check("wr_mem_addr", {28'd0, mem_addr}, {28'd0, a});
    check("wr_mem_wdata", mem_wdata, d);
    check("wr_busy_ready", {31'd0, req_ready}, 32'd0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready && n < 20);
    check("wr_latency", n, WR_LAT);
    check("wr_mem_en_off", {31'd0, mem_en}, 32'd0);
    if (!corrupt) exp_mem[a] = d;
  endtask

  // Burst read; optional stall of stall_cyc cycles on beat stall_beat;
  // hold keeps a write request pending on req_valid during the burst.
  task automatic do_read(input logic [3:0] a, input logic [3:0] len,
                         input int stall_beat, input int stall_cyc, input bit hold);
    int beats;
    int guard;
    int stall;
    logic [3:0] idx;
    beats = 0; guard = 0; stall = 0;
    req_valid = 1'b1; req_wr = 1'b0; req_addr = a; req_len = len;
    check("rd_req_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    if (hold) begin
      req_wr = 1'b1; req_addr = 4'h5; req_wdata = 32'h0000_0055;
    end else begin
      req_valid = 1'b0;
    end
    while (beats <= int'(len) && guard < 200) begin
      check("rd_mem_en_low", {31'd0, mem_en}, 32'd0);
      if (hold) check("rd_hold_ready", {31'd0, req_ready}, 32'd0);
      if (rsp_valid) begin
        idx = a + beats[3:0];
        check("rd_data", rsp_data, exp_mem[idx]);
        check("rd_last", {31'd0, rsp_last}, (beats == int'(len)) ? 32'd1 : 32'd0);
        if (beats == stall_beat && stall < stall_cyc) begin
          rsp_ready = 1'b0;
          stall++;
        end else begin
          rsp_ready = 1'b1;
          beats++;
        end
      end else begin
        rsp_ready = 1'b0;
      end
      @(negedge clk);
      guard++;
    end
    rsp_ready = 1'b0;
    check("rd_beats", beats, int'(len) + 1);
    check("rd_cycles", guard, 2 * (int'(len) + 1) + stall_cyc);
    check("rd_end_valid", {31'd0, rsp_valid}, 32'd0);
    check("rd_end_ready", {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    int b;
    int g;
    n_assert = 0; n_fail = 0; corrupt = 1'b0;
    for (int i = 0; i < 16; i++) begin
      ram[i] = 32'hC0DE_0000 + i;
      exp_mem[i] = 32'hC0DE_0000 + i;
    end
    rst = 1'b1; req_valid = 1'b0; req_wr = 1'b0; req_addr = 4'h0;
    req_len = 4'h0; req_wdata = 32'h0; rsp_ready = 1'b0;
    @(negedge clk); @(negedge clk);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_last", {31'd0, rsp_last}, 32'd0);
    check("rst_rsp_data", rsp_data, 32'd0);
    check("rst_mem_en", {31'd0, mem_en}, 32'd0);
    check("rst_mem_addr", {28'd0, mem_addr}, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_wr_err", {31'd0, wr_err}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);

    // Single write then single-beat read back.
    do_write(4'h3, 32'hDEAD_BEEF);
    do_read(4'h3, 4'h0, -1, 0, 1'b0);

    // Wrapping burst across the top of the address space.
    do_write(4'hE, 32'h0000_0011);
    do_write(4'hF, 32'h0000_0022);
    do_write(4'h0, 32'h0000_0033);
    do_read(4'hE, 4'h2, -1, 0, 1'b0);

    // Backpressure: five-cycle stall on beat 1 of a four-beat burst.
    do_read(4'h8, 4'h3, 1, 5, 1'b0);

    // Request held during a burst is only taken once the controller is idle.
    do_read(4'h4, 4'h1, -1, 0, 1'b1);
    @(negedge clk);
    req_valid = 1'b0; req_wr = 1'b0;
    check("hold_mem_en", {31'd0, mem_en}, 32'd1);
    check("hold_mem_addr", {28'd0, mem_addr}, 32'd5);
    check("hold_mem_wdata", mem_wdata, 32'h0000_0055);
    exp_mem[5] = 32'h0000_0055;
    for (int i = 0; i < WR_LAT; i++) @(negedge clk);
    check("hold_idle", {31'd0, req_ready}, 32'd1);
    do_read(4'h5, 4'h0, -1, 0, 1'b0);

    // Reset during beat 2 of a four-beat burst.
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 4'h0; req_len = 4'h3;
    @(negedge clk);
    req_valid = 1'b0;
    b = 0; g = 0;
    while (!(rsp_valid && b == 2) && g < 50) begin
      rsp_ready = rsp_valid;
      if (rsp_valid) b++;
      @(negedge clk);
      g++;
    end
    check("abort_reached_beat2", b, 2);
    check("abort_pre_valid", {31'd0, rsp_valid}, 32'd1);
    rst = 1'b1;
    #1;
    check("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("abort_rsp_last", {31'd0, rsp_last}, 32'd0);
    check("abort_rsp_data", rsp_data, 32'd0);
    check("abort_mem_en", {31'd0, mem_en}, 32'd0);
    rsp_ready = 1'b1;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("post_abort_valid", {31'd0, rsp_valid}, 32'd0);
      check("post_abort_ready", {31'd0, req_ready}, 32'd1);
      check("post_abort_mem_en", {31'd0, mem_en}, 32'd0);
    end
    rsp_ready = 1'b0;
    check("wr_err_clean", {31'd0, wr_err}, 32'd0);

`ifdef MEM_ACCESS_CTRL_VERIFY_EN
    // Corrupted write must raise the sticky error flag.
    corrupt = 1'b1;
    do_write(4'h7, 32'hA5A5_A5A5);
    corrupt = 1'b0;
    check("verify_err_set", {31'd0, wr_err}, 32'd1);
    do_write(4'h9, 32'h0000_1234);
    check("verify_err_sticky", {31'd0, wr_err}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("verify_err_cleared", {31'd0, wr_err}, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
